// File: rtl/dct_pipe_pkg.sv
// Shared widths, reset constants and the operand-window slot record
// for the bit-serial DCT adder datapath.
package dct_pipe_pkg;

    localparam int OPND_W = 8;
    localparam int SUM_W = 9;
    localparam int STAGES = 8;
    localparam logic [STAGES-1:0] OP_RESET = 8'b00000001;
    localparam int PAIR_W = 2 * OPND_W + 1;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic              opbit;
        logic              tag;
    } slot_t;

    function automatic slot_t slot_fill(
        input logic [OPND_W-1:0] a,
        input logic [OPND_W-1:0] b,
        input logic              opbit,
        input logic              tag
    );
        slot_t s;
        s.a = a;
        s.b = b;
        s.opbit = opbit;
        s.tag = tag;
        return s;
    endfunction

endpackage

// File: rtl/feeder_fifo.sv
// Small synchronous operand-pair FIFO with occupancy count and
// empty/full flags; writes past full and reads past empty are ignored.
module feeder_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/add_feeder.sv
// Operand feeder for the bit-serial adder array: buffers pairs, drives
// the diagonal operand window and re-aligns staggered sum bits.
module add_feeder
    import dct_pipe_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPND_W-1:0]        in_a,
    input  logic [OPND_W-1:0]        in_b,
    input  logic                     in_op,
    input  logic                     fb_load,
    input  logic [OPND_W-1:0]        fb_a,
    input  logic [OPND_W-1:0]        fb_b,
    output logic [STAGES*OPND_W-1:0] a_bus,
    output logic [STAGES*OPND_W-1:0] b_bus,
    output logic [STAGES-1:0]        op,
    input  logic [SUM_W-1:0]         s_in,
    output logic                     res_valid,
    output logic [SUM_W-1:0]         res_data
);

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [PAIR_W-1:0] head;
    slot_t             nxt;
    slot_t             win [STAGES];
    logic [ADD_LAT-1:0] tag_dly;
    logic [SUM_W-1:0]  skew;

    assign in_ready  = ~fifo_full & ~reset;
    assign fifo_push = in_valid & in_ready;

    feeder_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(PAIR_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({in_op, in_a, in_b}),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Feedback owns slot 7 outright; a waiting FIFO head stays put.
    always_comb begin
        nxt = '0;
        fifo_pop = 1'b0;
        priority case (1'b1)
            fb_load: begin
                nxt = slot_fill(fb_a, fb_b, 1'b0, 1'b1);
            end
            !fifo_empty: begin
                nxt = slot_fill(head[2*OPND_W-1:OPND_W],
                                head[OPND_W-1:0],
                                head[PAIR_W-1], 1'b1);
                fifo_pop = 1'b1;
            end
            default: begin
                nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                win[k] <= slot_fill('0, '0, OP_RESET[STAGES-1-k], 1'b0);
            end
        end else begin
            for (int k = 0; k < STAGES - 1; k++) begin
                win[k] <= win[k+1];
            end
            win[STAGES-1] <= nxt;
        end
    end

    // The op word is the slot chain's op bits, newest (slot 7) in bit 0.
    always_comb begin
        a_bus = '0;
        b_bus = '0;
        op = '0;
        for (int k = 0; k < STAGES; k++) begin
            a_bus[k*OPND_W +: OPND_W] = win[k].a;
            b_bus[k*OPND_W +: OPND_W] = win[k].b;
            op[STAGES-1-k] = win[k].opbit;
        end
    end

    // Tags leave slot 0 after 8 cycles and wait ADD_LAT more here.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_dly <= '0;
        end else begin
            tag_dly[0] <= win[0].tag;
            for (int m = 1; m < ADD_LAT; m++) begin
                tag_dly[m] <= tag_dly[m-1];
            end
        end
    end

    for (genvar k = 0; k < SUM_W; k++) begin : g_skew
        localparam int LEN = (k == SUM_W - 1) ? 1 : STAGES - k;
        logic [LEN-1:0] dly;

        always_ff @(posedge clk) begin
            if (reset) begin
                dly <= '0;
            end else begin
                dly[0] <= s_in[k];
                for (int m = 1; m < LEN; m++) begin
                    dly[m] <= dly[m-1];
                end
            end
        end

        assign skew[k] = dly[LEN-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            res_valid <= tag_dly[ADD_LAT-1];
            if (tag_dly[ADD_LAT-1]) begin
                res_data <= skew;
            end
        end
    end

endmodule

// File: tb/tb_add_feeder.sv
// Self-checking bench for add_feeder: directed vectors, corner sequences
// and a randomized phase against a queue-based reference model.
module tb_add_feeder;
    import dct_pipe_pkg::*;

    localparam int FIFO_DEPTH = 4;
    localparam int ADD_LAT = 1;
    localparam int LAT = ADD_LAT + STAGES;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_op;
    logic        fb_load;
    logic [7:0]  fb_a;
    logic [7:0]  fb_b;
    logic [63:0] a_bus;
    logic [63:0] b_bus;
    logic [7:0]  op;
    logic [8:0]  s_in;
    logic        res_valid;
    logic [8:0]  res_data;

    add_feeder #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .ADD_LAT(ADD_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .fb_load   (fb_load),
        .fb_a      (fb_a),
        .fb_b      (fb_b),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .op        (op),
        .s_in      (s_in),
        .res_valid (res_valid),
        .res_data  (res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder array model: a pair loaded at edge t sits in slot 8-ADD_LAT-k
    // just before edge t+ADD_LAT+k, when its sum bit k is sampled.
    function automatic logic [8:0] slot_sum(input logic [63:0] ab,
                                            input logic [63:0] bb,
                                            input int idx);
        return {1'b0, ab[idx*8 +: 8]} + {1'b0, bb[idx*8 +: 8]};
    endfunction

    always_comb begin
        logic [8:0] t;
        t = '0;
        s_in = '0;
        for (int k = 0; k < 8; k++) begin
            t = slot_sum(a_bus, b_bus, 8 - ADD_LAT - k);
            s_in[k] = t[k];
        end
        t = slot_sum(a_bus, b_bus, 8 - ADD_LAT - 7);
        s_in[8] = t[8];
    end

    typedef struct { logic [7:0] a; logic [7:0] b; logic op; } pair_t;
    typedef struct { int due; logic [8:0] d; } exp_t;
    typedef struct { int cyc; logic [8:0] d; } obs_t;
    typedef struct { logic [7:0] a; logic [7:0] b; logic op; logic [8:0] sum; } vec_t;

    pair_t      mq[$];
    exp_t       eq[$];
    obs_t       obs[$];
    logic [7:0] ma [8];
    logic [7:0] mb [8];
    logic [7:0] mop;
    logic [8:0] mlast;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timed out at cyc=%0d", nm, cyc);
    endtask

    // Reference model, stepped once per rising edge on pre-edge inputs.
    always @(posedge clk) begin : model
        pair_t      p;
        logic [7:0] la;
        logic [7:0] lb;
        logic       lop;
        logic       ltag;
        logic       rdy;
        logic       ev;
        logic [8:0] ed;
        logic [63:0] pa;
        logic [63:0] pb;
        cyc++;
        ev = 1'b0;
        if (reset) begin
            mq.delete();
            eq.delete();
            for (int k = 0; k < 8; k++) begin
                ma[k] = '0;
                mb[k] = '0;
            end
            mop = 8'h01;
            mlast = '0;
        end else begin
            la = '0;
            lb = '0;
            lop = 1'b0;
            ltag = 1'b0;
            rdy = (mq.size() < FIFO_DEPTH);
            if (fb_load) begin
                la = fb_a;
                lb = fb_b;
                ltag = 1'b1;
            end else if (mq.size() > 0) begin
                p = mq.pop_front();
                la = p.a;
                lb = p.b;
                lop = p.op;
                ltag = 1'b1;
            end
            if (in_valid && rdy) mq.push_back('{in_a, in_b, in_op});
            for (int k = 0; k < 7; k++) begin
                ma[k] = ma[k+1];
                mb[k] = mb[k+1];
            end
            ma[7] = la;
            mb[7] = lb;
            mop = {mop[6:0], lop};
            if (ltag) eq.push_back('{cyc + LAT, {1'b0, la} + {1'b0, lb}});
            if (eq.size() > 0 && eq[0].due == cyc) begin
                ev = 1'b1;
                mlast = eq[0].d;
                void'(eq.pop_front());
            end
        end
        ed = mlast;
        for (int k = 0; k < 8; k++) begin
            pa[k*8 +: 8] = ma[k];
            pb[k*8 +: 8] = mb[k];
        end
        #1;
        chk("a_bus", a_bus, pa);
        chk("b_bus", b_bus, pb);
        chk("op", op, mop);
        chk("in_ready", in_ready, (mq.size() < FIFO_DEPTH) && !reset);
        chk("res_valid", res_valid, ev);
        chk("res_data", res_data, ed);
        if (res_valid) obs.push_back('{cyc, res_data});
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Offers a pair from the next falling edge until accepted; returns the
    // index of the accepting edge. Leaves in_valid high for back-to-back use.
    task automatic push_one(input logic [7:0] a, input logic [7:0] b,
                            input logic o, output int acc);
        bit ok;
        ok = 1'b0;
        acc = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = o;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                @(posedge clk);
                #2;
                acc = cyc;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail("push_accept");
    endtask

    task automatic wait_result(input string nm, input int want_cyc, input logic [8:0] want_d);
        int n;
        n = 0;
        while (obs.size() == 0 && n < LAT + 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (obs.size() == 0) begin
            fail(nm);
        end else begin
            chk({nm, "_lat"}, obs[0].cyc, want_cyc);
            chk({nm, "_data"}, obs[0].d, want_d);
        end
    endtask

    vec_t vecs[7];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int acc;
        int accepts;
        int n;
        vecs[0] = '{8'h12, 8'h34, 1'b1, 9'h046};
        vecs[1] = '{8'hFF, 8'hFF, 1'b0, 9'h1FE};
        vecs[2] = '{8'h80, 8'h80, 1'b1, 9'h100};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 9'h000};
        vecs[4] = '{8'hFF, 8'h01, 1'b1, 9'h100};
        vecs[5] = '{8'h55, 8'hAA, 1'b0, 9'h0FF};
        vecs[6] = '{8'h7F, 8'h01, 1'b1, 9'h080};

        reset = 1'b1;
        in_valid = 1'b1;
        in_a = 8'h5A;
        in_b = 8'hA5;
        in_op = 1'b1;
        fb_load = 1'b0;
        fb_a = '0;
        fb_b = '0;

        repeat (3) begin
            @(posedge clk);
            #2;
            chk("rst_ready", in_ready, 0);
            chk("rst_op", op, 8'h01);
            chk("rst_abus", a_bus, 0);
            chk("rst_valid", res_valid, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("ready_after_reset", in_ready, 1);
        idle(2);

        for (int i = 0; i < 7; i++) begin
            obs.delete();
            push_one(vecs[i].a, vecs[i].b, vecs[i].op, acc);
            chk("no_bypass", a_bus[63:56], 0);
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
            #2;
            chk("vec_slot7_a", a_bus[63:56], vecs[i].a);
            chk("vec_slot7_b", b_bus[63:56], vecs[i].b);
            chk("vec_op0", op[0], vecs[i].op);
            wait_result("vec", acc + 1 + LAT, vecs[i].sum);
            idle(2);
        end

        obs.delete();
        for (int i = 1; i <= 20; i++) begin
            push_one(8'(i), 8'(2 * i), 1'b0, acc);
        end
        idle(1);
        n = 0;
        while (obs.size() < 20 && n < 60) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("stream_count", obs.size(), 20);
        if (obs.size() >= 20) begin
            for (int i = 0; i < 20; i++) begin
                chk("stream_data", obs[i].d, 9'(3 * (i + 1)));
            end
            chk("stream_gapless", obs[19].cyc - obs[0].cyc, 19);
        end
        idle(3);

        fb_load = 1'b1;
        fb_a = 8'h00;
        fb_b = 8'h00;
        push_one(8'h11, 8'h21, 1'b1, acc);
        push_one(8'h12, 8'h22, 1'b0, acc);
        push_one(8'h13, 8'h23, 1'b1, acc);
        @(negedge clk);
        in_valid = 1'b0;
        fb_a = 8'hAA;
        fb_b = 8'h55;
        @(posedge clk);
        #2;
        chk("fb_slot7_a", a_bus[63:56], 8'hAA);
        chk("fb_slot7_b", b_bus[63:56], 8'h55);
        chk("fb_op0", op[0], 0);
        @(negedge clk);
        fb_load = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #2;
            chk("fb_queue_a", a_bus[63:56], 8'(8'h11 + j));
            chk("fb_queue_b", b_bus[63:56], 8'(8'h21 + j));
        end
        @(posedge clk);
        #2;
        chk("fb_queue_drained", a_bus[63:56], 0);
        idle(12);

        fb_load = 1'b1;
        fb_a = 8'h01;
        fb_b = 8'h02;
        accepts = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = 8'(8'h40 + accepts);
            in_b = 8'(accepts);
            in_op = 1'b0;
            #1;
            if (in_ready) accepts++;
        end
        chk("full_accepts", accepts, FIFO_DEPTH);
        chk("full_ready_low", in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0;
        fb_load = 1'b0;
        for (int j = 0; j < FIFO_DEPTH; j++) begin
            @(posedge clk);
            #2;
            chk("full_drain_a", a_bus[63:56], 8'(8'h40 + j));
        end
        @(posedge clk);
        #2;
        chk("full_no_dup", a_bus[63:56], 0);
        idle(12);

        for (int i = 0; i < 5; i++) begin
            push_one(8'(8'h20 + i), 8'h30, 1'b1, acc);
        end
        idle(3);
        @(negedge clk);
        reset = 1'b1;
        obs.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk("post_reset_silent", obs.size(), 0);
        obs.delete();
        push_one(8'h21, 8'h43, 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        wait_result("post_reset", acc + 1 + LAT, 9'h064);
        idle(3);

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 99) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            fb_load = ($urandom_range(0, 5) == 0);
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            in_op = 1'($urandom);
            fb_a = 8'($urandom);
            fb_b = 8'($urandom);
        end
        @(negedge clk);
        reset = 1'b0;
        fb_load = 1'b0;
        idle(LAT + 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_feeder.md
# add_feeder

Operand-side companion to the bit-serial `pipeline_add` array in the approximate 1-D DCT datapath. It accepts operand pairs over a valid/ready handshake, buffers them, and drives the eight-slot diagonal operand window (A0..A7, B0..B7) and the op-shift word every cycle. On feedback cycles it inserts the recirculated partial sums Y0/Y1. It also de-skews the staggered sum bits S back into whole 9-bit results.

## Interface
Parameters:
- FIFO_DEPTH, 4: input buffer entries (power of two, ≥2)
- ADD_LAT, 1: cycles from a pair entering slot 7 to S[0] of its sum being valid at `s_in`

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  operand pair offered
- in_ready  out  1  pair accepted on clk when in_valid & in_ready
- in_a, in_b  in  8  operands
- in_op  in  1  per-pair op bit (shifted into `op`)
- fb_load  in  1  feedback slot this cycle (driven from counter phase Q==2)
- fb_a, fb_b  in  8  recirculated sums (Y0[8:1], Y1[8:1])
- a_bus, b_bus  out  64  slot k on bits [8k+7:8k]; slot 0 oldest
- op  out  8  op shift word, bit 0 newest
- s_in  in  9  sum bits from adder array
- res_valid  out  1  one-cycle result strobe
- res_data  out  9  de-skewed sum

## Operation
- Window advances every cycle, no stall: slot k ← slot k+1 for k=0..6.
- Slot 7 load priority: fb_load → {fb_a, fb_b}, op bit 0, tag valid. FIFO non-empty → FIFO head, in_op, tag valid, pop. Otherwise → bubble: zeros, op bit 0, tag invalid.
- op ← {op[6:0], new op bit} each cycle.
- FIFO: in_ready = (count < FIFO_DEPTH) & ~reset. A push while full is impossible because ready is low, even if a pop occurs the same cycle. A simultaneous push and pop leaves count unchanged. A push into an empty FIFO is not bypassed: the pair loads slot 7 no earlier than the next cycle.
- Feedback never pops the FIFO. A pending head waits.
- De-skew: for a tagged entry loaded into slot 7 at edge t:
  - S[k] is sampled at t+ADD_LAT+k for k=0..7.
  - S[8] is sampled together with S[7].
- Width rule: res_data is the raw 9-bit word. No truncation or sign handling is done here.
- Bubble entries produce no res_valid. Feedback entries do produce one.

## Timing
- Reset values: a_bus=0, b_bus=0, op=8'b00000001, res_valid=0, res_data=0, FIFO empty, all tags invalid, in_ready=0.
- Reset mid-operation: a reset asserted during an edge flushes the FIFO, window, tags and de-skew bank on that edge. No res_valid may appear for pre-reset entries.
- Input-to-slot-7 latency: 1 cycle minimum with an empty FIFO and no fb_load.
- Result latency: res_data/res_valid are registered at edge t+ADD_LAT+8 after the slot-7 load at t.
- Throughput: one result per cycle, sustained.
- res_data holds its last value when res_valid is low.
- No backpressure on results. Downstream must sample on strobe.

## Structure
- Package `dct_pipe_pkg`:
  - OPND_W=8, SUM_W=9, STAGES=8, OP_RESET=8'b00000001
  - slot record typedef {a, b, opbit, tag}
- Sub-module `feeder_fifo`: synchronous FIFO with count, push/pop, and empty/full flags.
- Top-level contents:
  - slot shift chain
  - op register
  - tag delay line of length ADD_LAT+8
  - per-bit de-skew delay lines, where bit k is delayed 8-k cycles and bit 8 is delayed 1 cycle

## Test plan
- Reset check: hold reset for 3 cycles with in_valid=1 → in_ready=0, op=8'h01, a_bus=0, res_valid never high; after release, in_ready=1.
- Single pair: in_a=8'h12, in_b=8'h34, in_op=1, with a model adder driving S=a+b bit k at the spec'd cycles → slot 7 holds 12/34 one cycle after accept; res_data=9'h046 with res_valid at ADD_LAT+8 after the load; op bit 0=1 on the load cycle.
- Back-to-back stream: push pairs (i, 2i) for i=1..20 with no stalls → 20 consecutive res_valid strobes, data 3i, in order, with no gaps.
- Feedback insertion: with FIFO holding 3 entries, pulse fb_load with fb_a=8'hAA, fb_b=8'h55 → slot 7=AA/55, FIFO count unchanged, and the queued entries follow in order one cycle later.
- Full/backpressure: hold in_valid and force feedback every cycle so nothing pops → in_ready drops after exactly FIFO_DEPTH accepts; no entry is lost or duplicated after release.
- Reset mid-stream: assert reset with 5 results in flight → no res_valid afterwards until new input; the first post-reset result arrives at the nominal latency.
